// File: rtl/i2c_config_seq.sv
// Codec register-table sequencer: walks a ROM of 16-bit words and
// writes each one to the I2C host as START/addr/hi/lo/STOP with retries.
module i2c_config_seq #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         NUM_REGS   = 11,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 1024,
  localparam int        IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [IW-1:0] err_idx,
  output logic [IW-1:0] tbl_idx,
  input  logic [15:0]   tbl_data,
  output logic          i2c_start,
  output logic          i2c_stop,
  output logic          i2c_write,
  output logic          i2c_read,
  output logic [7:0]    i2c_wr_data,
  input  logic          i2c_done,
  input  logic          i2c_ack
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT, GAP, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] eidx_q, eidx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   word_q, word_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          fail_q, fail_d;
  logic          fph_q, fph_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          wr_q, wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      idx_q   <= '0;
      eidx_q  <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      fail_q  <= 1'b0;
      fph_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      fail_q  <= fail_d;
      fph_q   <= fph_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idx_d   = idx_q;
    eidx_d  = eidx_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    fail_d  = fail_q;
    fph_d   = fph_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    start_d = 1'b0;
    stop_d  = 1'b0;
    wr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          fail_d  = 1'b0;
          fph_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // first cycle lets the sync ROM catch up with idx_q
        if (!fph_q) begin
          fph_d = 1'b1;
        end else begin
          fph_d   = 1'b0;
          word_d  = tbl_data;
          step_d  = 3'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        unique case (1'b1)
          (step_q == 3'd0): start_d = 1'b1;
          (step_q == 3'd1): begin
            wr_d    = 1'b1;
            wdata_d = {DEV_ADDR, 1'b0};
          end
          (step_q == 3'd2): begin
            wr_d    = 1'b1;
            wdata_d = word_q[15:8];
          end
          (step_q == 3'd3): begin
            wr_d    = 1'b1;
            wdata_d = word_q[7:0];
          end
          default: stop_d = 1'b1;
        endcase
      end
      WAIT: begin
        if (i2c_done) begin
          state_d = ISSUE;
          if (step_q == 3'd0) begin
            step_d = 3'd1;
          end else if (step_q >= 3'd4) begin
            gap_d   = GW'(GAP_CYCLES - 1);
            state_d = GAP;
          end else if (i2c_ack) begin
            step_d = step_q + 3'd1;
          end else begin
            fail_d = 1'b1;
            step_d = 3'd4;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (fail_q) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            fail_d  = 1'b0;
            state_d = FETCH;
          end else begin
            err_d   = 1'b1;
            eidx_d  = idx_q;
            state_d = FIN;
          end
        end else if (idx_q == IW'(NUM_REGS - 1)) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          idx_d   = idx_q + IW'(1);
          retry_d = '0;
          state_d = FETCH;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign err_idx     = eidx_q;
  assign tbl_idx     = idx_q;
  assign i2c_start   = start_q;
  assign i2c_stop    = stop_q;
  assign i2c_write   = wr_q;
  assign i2c_read    = 1'b0;
  assign i2c_wr_data = wdata_q;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench for i2c_config_seq: ROM and I2C host models plus
// per-scenario tasks comparing the captured command stream.
module tb_i2c_config_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        busy, done, error;
  logic [1:0]  err_idx, tbl_idx;
  logic [15:0] tbl_data;
  logic        i2c_start, i2c_stop, i2c_write, i2c_read;
  logic [7:0]  i2c_wr_data;
  logic        i2c_done, i2c_ack;

  int n_checks = 0;
  int n_errors = 0;

  i2c_config_seq #(
    .DEV_ADDR(7'h1A), .NUM_REGS(3), .MAX_RETRY(3), .GAP_CYCLES(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .busy(busy), .done(done), .error(error),
    .err_idx(err_idx), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_write(i2c_write), .i2c_read(i2c_read),
    .i2c_wr_data(i2c_wr_data),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (tbl_idx)
      2'd0:    tbl_data <= 16'h1E00;
      2'd1:    tbl_data <= 16'h0C10;
      2'd2:    tbl_data <= 16'h1201;
      default: tbl_data <= 16'hDEAD;
    endcase
  end

  // host model: 1=START 2=WRITE 3=STOP, log entries {type, byte}
  int          mode = 0;
  logic        host_clr = 1'b0;
  logic [9:0]  log_q[$];
  logic [9:0]  exp_q[$];
  int          cyc = 0;
  int          entry, pos, hcnt, ptype;
  bit          ok_txn, used, pend, after_stop;
  logic [7:0]  pbyte;
  int          last_done_cyc = -100000;
  int          min_gap = 1000000;
  int          gap_delta = -1;
  int          multi = 0;
  int          stab_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_done <= 1'b0;
      i2c_ack  <= 1'b0;
      pend     <= 1'b0;
      hcnt     <= 0;
      entry    <= 0;
      pos      <= 0;
      ok_txn   <= 1'b0;
    end else begin
      i2c_done <= 1'b0;
      if (int'(i2c_start) + int'(i2c_stop) + int'(i2c_write) > 1)
        multi <= multi + 1;
      if (host_clr) begin
        log_q.delete();
        entry         <= 0;
        pos           <= 0;
        used          <= 1'b0;
        pend          <= 1'b0;
        last_done_cyc <= -100000;
        min_gap       <= 1000000;
        gap_delta     <= -1;
        after_stop    <= 1'b0;
        stab_err      <= 0;
      end else if (i2c_start || i2c_stop || i2c_write) begin
        if (cyc - last_done_cyc < min_gap)
          min_gap <= cyc - last_done_cyc;
        if (i2c_start && after_stop)
          gap_delta <= cyc - last_done_cyc;
        pend  <= 1'b1;
        hcnt  <= 2;
        pbyte <= i2c_wr_data;
        if (i2c_start) begin
          ptype  <= 1;
          pos    <= 0;
          ok_txn <= 1'b1;
          log_q.push_back({2'd1, 8'h00});
        end else if (i2c_write) begin
          ptype <= 2;
          pos   <= pos + 1;
          log_q.push_back({2'd2, i2c_wr_data});
        end else begin
          ptype <= 3;
          log_q.push_back({2'd3, 8'h00});
        end
      end else if (pend) begin
        if (hcnt == 0) begin
          pend          <= 1'b0;
          i2c_done      <= 1'b1;
          last_done_cyc <= cyc + 1;
          after_stop    <= (ptype == 3);
          if (ptype == 2) begin
            if (i2c_wr_data !== pbyte) stab_err <= stab_err + 1;
            if ((mode == 1 && entry == 1 && pos == 1 && !used) ||
                (mode == 2 && entry == 2 && pos == 3)) begin
              i2c_ack <= 1'b0;
              ok_txn  <= 1'b0;
              if (mode == 1) used <= 1'b1;
            end else begin
              i2c_ack <= 1'b1;
            end
          end else begin
            i2c_ack <= 1'b0;
            if (ptype == 3 && ok_txn && pos == 3) entry <= entry + 1;
          end
        end else begin
          hcnt <= hcnt - 1;
        end
      end
    end
  end

  task automatic clear_host();
    @(negedge clk) host_clr = 1'b1;
    @(negedge clk) host_clr = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic run_seq(input int budget, output int dones,
                         output int both, output bit tmo);
    dones = 0;
    both  = 0;
    tmo   = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (done && error) both++;
      if (!busy) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic add_full(input logic [15:0] w);
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd2, 8'h34});
    exp_q.push_back({2'd2, w[15:8]});
    exp_q.push_back({2'd2, w[7:0]});
    exp_q.push_back({2'd3, 8'h00});
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, error, i2c_start, i2c_stop, i2c_write, i2c_read}
        !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_flags got=%b want=0",
        {busy, done, error, i2c_start, i2c_stop, i2c_write, i2c_read});
    end
    n_checks++;
    if ({tbl_idx, err_idx, i2c_wr_data} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_values got=%h want=000",
        {tbl_idx, err_idx, i2c_wr_data});
    end
  endtask

  task automatic test_all_ack();
    int d, b;
    bit t;
    mode = 0;
    clear_host();
    @(negedge clk) go = 1'b1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_before_go got=%b want=0", busy);
    end
    @(negedge clk) go = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_after_go got=%b want=1", busy);
    end
    run_seq(2000, d, b, t);
    n_checks++;
    if (t || d != 1 || b != 0 || error !== 1'b0) begin
      n_errors++;
      $display("FAIL all_ack_end tmo=%0d done=%0d both=%0d err=%b want 0/1/0/0",
               t, d, b, error);
    end
    exp_q.delete();
    add_full(16'h1E00);
    add_full(16'h0C10);
    add_full(16'h1201);
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL all_ack_len got=%0d want=%0d", log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (log_q[i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL all_ack_cmd[%0d] got=%h want=%h", i, log_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (gap_delta != 9) begin
      n_errors++;
      $display("FAIL gap_timing got=%0d want=9", gap_delta);
    end
    n_checks++;
    if (min_gap != 2) begin
      n_errors++;
      $display("FAIL cmd_spacing got=%0d want=2", min_gap);
    end
    n_checks++;
    if (stab_err != 0 || multi != 0) begin
      n_errors++;
      $display("FAIL pulse_integrity got=%0d/%0d want=0/0", stab_err, multi);
    end
  endtask

  task automatic test_nack_once();
    int d, b, starts;
    bit t;
    mode = 1;
    clear_host();
    pulse_go();
    run_seq(2000, d, b, t);
    n_checks++;
    if (t || d != 1 || error !== 1'b0) begin
      n_errors++;
      $display("FAIL nack_once_end tmo=%0d done=%0d err=%b want 0/1/0", t, d, error);
    end
    exp_q.delete();
    add_full(16'h1E00);
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd2, 8'h34});
    exp_q.push_back({2'd3, 8'h00});
    add_full(16'h0C10);
    add_full(16'h1201);
    starts = 0;
    foreach (log_q[i]) if (log_q[i][9:8] == 2'd1) starts++;
    n_checks++;
    if (starts != 4) begin
      n_errors++;
      $display("FAIL nack_once_starts got=%0d want=4", starts);
    end
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL nack_once_len got=%0d want=%0d", log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (log_q[i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL nack_once_cmd[%0d] got=%h want=%h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_retry_exhaust();
    int d, b;
    bit t;
    mode = 2;
    clear_host();
    pulse_go();
    run_seq(4000, d, b, t);
    n_checks++;
    if (t || d != 0 || b != 0) begin
      n_errors++;
      $display("FAIL exhaust_end tmo=%0d done=%0d both=%0d want 0/0/0", t, d, b);
    end
    n_checks++;
    if (error !== 1'b1 || err_idx !== 2'd2) begin
      n_errors++;
      $display("FAIL exhaust_err got=%b/%0d want=1/2", error, err_idx);
    end
    exp_q.delete();
    add_full(16'h1E00);
    add_full(16'h0C10);
    for (int k = 0; k < 4; k++) add_full(16'h1201);
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL exhaust_len got=%0d want=%0d", log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (log_q[i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL exhaust_cmd[%0d] got=%h want=%h", i, log_q[i], exp_q[i]);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL error_held got=%b/%b want=1/0", error, busy);
    end
    mode = 0;
    clear_host();
    pulse_go();
    n_checks++;
    if (error !== 1'b0) begin
      n_errors++;
      $display("FAIL error_clear got=%b want=0", error);
    end
    run_seq(2000, d, b, t);
    n_checks++;
    if (t || d != 1 || error !== 1'b0) begin
      n_errors++;
      $display("FAIL after_error_run tmo=%0d done=%0d err=%b want 0/1/0", t, d, error);
    end
  endtask

  task automatic test_go_ignored();
    int d, b;
    bit t;
    mode = 0;
    clear_host();
    pulse_go();
    repeat (40) @(negedge clk);
    pulse_go();
    n_checks++;
    if (busy !== 1'b1 || tbl_idx !== 2'd1) begin
      n_errors++;
      $display("FAIL go_mid_state got=%b/%0d want=1/1", busy, tbl_idx);
    end
    run_seq(2000, d, b, t);
    n_checks++;
    if (t || d != 1) begin
      n_errors++;
      $display("FAIL go_mid_end tmo=%0d done=%0d want 0/1", t, d);
    end
    exp_q.delete();
    add_full(16'h1E00);
    add_full(16'h0C10);
    add_full(16'h1201);
    n_checks++;
    if (log_q != exp_q) begin
      n_errors++;
      $display("FAIL go_mid_order got_len=%0d want_len=%0d", log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d, b;
    bit t, seen;
    mode = 0;
    clear_host();
    pulse_go();
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (i2c_write && i2c_wr_data == 8'h1E) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL reset_mid_wait got=timeout want=hi_byte");
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, error, i2c_start, i2c_stop, i2c_write, tbl_idx,
         err_idx, i2c_wr_data} !== 18'h0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs got=%h want=0",
        {busy, done, error, i2c_start, i2c_stop, i2c_write, tbl_idx,
         err_idx, i2c_wr_data});
    end
    @(negedge clk) rst_n = 1'b1;
    clear_host();
    pulse_go();
    run_seq(2000, d, b, t);
    exp_q.delete();
    add_full(16'h1E00);
    add_full(16'h0C10);
    add_full(16'h1201);
    n_checks++;
    if (t || d != 1 || log_q != exp_q) begin
      n_errors++;
      $display("FAIL reset_restart tmo=%0d done=%0d len=%0d want 0/1/%0d",
               t, d, log_q.size(), exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_all_ack();
    test_nack_once();
    test_retry_exhaust();
    test_go_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
